// File: rtl/sram_init_array.sv
// sram_init_array
//
// Register-array SRAM with one write port and one read port. Its contents
// are defined by hardware rather than by simulator initial blocks. After
// reset release, and in READY whenever init_req is sampled, the array
// passes through an INIT phase before it accepts reads and writes again.
//
// Build option SRAM_INIT_HWCLR_EN:
//   defined   - INIT is a hardware sweep that writes INIT_VALUE to one entry
//               per rising edge, DEPTH edges in total. init_req starts a new
//               sweep.
//   undefined - there is no sweep counter, and INIT lasts a single edge.
//               Entries that have not been written since reset read as
//               INIT_VALUE, and init_req is ignored.
//
// Ports:
//   clk        sole clock; all state updates on the rising edge
//   rst_n      asynchronous, active-low reset
//   init_req   request a new clear sweep (sampled only in READY)
//   init_done  high in READY; gates acceptance of wen/ren
//   wen/waddr/wdata  write port; addresses >= DEPTH are dropped
//   ren/raddr        read port; addresses >= DEPTH read as 0
//   rdata      registered read data, 0 whenever rvalid is 0
//   rvalid     one-cycle pulse, one cycle after an accepted ren
//   is_zero    registered, rvalid && rdata == 0
//
// Handshake: no back-pressure. An enable is accepted on any rising edge
// where init_done is high. Each accepted ren produces exactly one rvalid
// pulse on the following cycle, and rdata/is_zero are qualified by it.
// The init_done output is the FSM state (1 = READY), so it doubles as the
// debug view of the state machine.

module sram_init_array #(
  parameter int unsigned       WIDTH      = 112,
  parameter int unsigned       DEPTH      = 32,
  parameter logic [WIDTH-1:0]  INIT_VALUE = {WIDTH{1'b0}},
  localparam int unsigned      ADDR_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_req,
  output logic              init_done,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              ren,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata,
  output logic              rvalid,
  output logic              is_zero
);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // One extra bit so that DEPTH itself is representable for range checks.
  localparam logic [ADDR_W:0] DEPTH_CMP = (ADDR_W+1)'(DEPTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mem [DEPTH];

  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [WIDTH-1:0]   mem_wdata;

  logic               wr_in_range;
  logic               rd_in_range;
  logic [WIDTH-1:0]   rd_entry;

  logic [WIDTH-1:0]   rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;
  logic               is_zero_q, is_zero_d;

  assign init_done   = (state_q == ST_READY);
  assign wr_in_range = ({1'b0, waddr} < DEPTH_CMP);
  assign rd_in_range = ({1'b0, raddr} < DEPTH_CMP);

`ifdef SRAM_INIT_HWCLR_EN
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // Next-state logic: sweep one entry per edge, then serve accesses.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST_IDX) begin
        state_d = ST_READY;
        cnt_d   = '0;
      end
    end else if (init_req) begin
      state_d = ST_INIT;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The sweep owns the write port during INIT, and user writes own it in
  // READY. A write in the same cycle as init_req still lands, and the sweep
  // overwrites it later.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdata = wdata;
    if (state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = INIT_VALUE;
    end else if (wen && wr_in_range) begin
      mem_we = 1'b1;
    end
  end

  assign rd_entry = mem[raddr];
`else
  // Without the sweep, a per-entry "written" flag stands in for the clear.
  // An entry that has not been written since reset reads as INIT_VALUE, so
  // the storage itself never needs an initial value.
  logic [DEPTH-1:0] loaded_q, loaded_d;
  logic             unused_init_req;

  assign unused_init_req = init_req;

  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT) begin
      state_d = ST_READY;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdata = wdata;
    if ((state_q == ST_READY) && wen && wr_in_range) begin
      mem_we = 1'b1;
    end
  end

  always_comb begin
    loaded_d = loaded_q;
    if (mem_we) begin
      loaded_d[mem_waddr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_INIT;
      loaded_q <= '0;
    end else begin
      state_q  <= state_d;
      loaded_q <= loaded_d;
    end
  end

  always_comb begin
    rd_entry = mem[raddr];
    if (!loaded_q[raddr]) begin
      rd_entry = INIT_VALUE;
    end
  end
`endif

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Read path. The write-first bypass forwards wdata when a write hits the
  // entry being read. Out-of-range reads still pulse rvalid but return 0.
  always_comb begin
    rvalid_d  = 1'b0;
    rdata_d   = '0;
    is_zero_d = 1'b0;
    if ((state_q == ST_READY) && ren) begin
      rvalid_d = 1'b1;
      if (rd_in_range) begin
        if (wen && (waddr == raddr)) begin
          rdata_d = wdata;
        end else begin
          rdata_d = rd_entry;
        end
      end
      is_zero_d = (rdata_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      is_zero_q <= 1'b0;
    end else begin
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      is_zero_q <= is_zero_d;
    end
  end

  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign is_zero = is_zero_q;

endmodule
